// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: word width, default vector length and the
// vector-burst state encoding used by the data-memory responder.
package cpu_pkg;

    localparam int WORD_W       = 16;
    localparam int VLEN_DEFAULT = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        VBURST = 1'b1
    } vstate_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port-write data memory with a registered read address; read data is
// valid the cycle after the address is presented and reflects a same-edge write.
module dmem_array
    import cpu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WORD_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0]     mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] raddr_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        raddr_q <= raddr;
    end

    assign rdata = mem[raddr_q];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: scalar ld/st with a 2-stage load pipe; vector vld/vst
// bursts are built only when DMEM_VEC_EN is defined.
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int VLEN       = VLEN_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic                   req_we,
    input  logic                   req_vec,
    input  logic [WORD_W-1:0]      req_addr,
    input  logic [WORD_W-1:0]      req_wdata,
    input  logic [WORD_W*VLEN-1:0] req_vwdata,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic                   rsp_vec,
    output logic [WORD_W-1:0]      rsp_data,
    output logic [WORD_W*VLEN-1:0] rsp_vdata
);

    localparam int VW = WORD_W * VLEN;

    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [DEPTH_LOG2-1:0] mem_raddr;
    logic [WORD_W-1:0]     mem_wdata;
    logic [WORD_W-1:0]     mem_rdata;
    logic                  rsp_valid_d, rsp_valid_q;
    logic [WORD_W-1:0]     rsp_data_d, rsp_data_q;
    logic                  unused_addr_bits;

    assign req_idx          = req_addr[DEPTH_LOG2-1:0];
    assign unused_addr_bits = ^req_addr[WORD_W-1:DEPTH_LOG2];

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .raddr(mem_raddr),
        .rdata(mem_rdata)
    );

`ifdef DMEM_VEC_EN
    localparam int                LANE_W    = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VLEN - 1);

    vstate_e               state_d, state_q;
    logic [LANE_W-1:0]     lane_d, lane_q;
    logic [DEPTH_LOG2-1:0] base_d, base_q;
    logic                  burst_we_d, burst_we_q;
    logic [VW-1:0]         vwdata_d, vwdata_q;
    logic                  ready_d, ready_q;
    logic                  s1_valid_d, s1_valid_q;
    logic                  s1_vec_d, s1_vec_q;
    logic                  s1_last_d, s1_last_q;
    logic [LANE_W-1:0]     s1_lane_d, s1_lane_q;
    logic [VW-1:0]         vbuf_d, vbuf_q;
    logic                  rsp_vec_d, rsp_vec_q;
    logic [VW-1:0]         rsp_vdata_d, rsp_vdata_q;
    logic [DEPTH_LOG2-1:0] lane_addr;

    // Adding in DEPTH_LOG2 bits gives the modulo-depth wrap for free.
    assign lane_addr = base_q + DEPTH_LOG2'(lane_q);

    // Lane 0 is handled in the accepting IDLE cycle; lanes 1..VLEN-1 in VBURST.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        base_d     = base_q;
        burst_we_d = burst_we_q;
        vwdata_d   = vwdata_q;
        s1_valid_d = 1'b0;
        s1_vec_d   = 1'b0;
        s1_last_d  = 1'b0;
        s1_lane_d  = '0;
        mem_we     = 1'b0;
        mem_waddr  = req_idx;
        mem_raddr  = req_idx;
        mem_wdata  = req_wdata;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mem_we     = req_we;
                    s1_valid_d = !req_we;
                    if (req_vec) begin
                        mem_wdata  = req_vwdata[WORD_W-1:0];
                        s1_vec_d   = 1'b1;
                        s1_last_d  = (VLEN == 1);
                        base_d     = req_idx;
                        burst_we_d = req_we;
                        vwdata_d   = req_vwdata;
                        if (VLEN > 1) begin
                            state_d = VBURST;
                            lane_d  = LANE_W'(1);
                        end
                    end
                end
            end
            VBURST: begin
                mem_we     = burst_we_q;
                mem_waddr  = lane_addr;
                mem_raddr  = lane_addr;
                mem_wdata  = vwdata_q[lane_q*WORD_W +: WORD_W];
                s1_valid_d = !burst_we_q;
                s1_vec_d   = 1'b1;
                s1_lane_d  = lane_q;
                s1_last_d  = (lane_q == LAST_LANE);
                if (lane_q == LAST_LANE) begin
                    state_d = IDLE;
                    lane_d  = '0;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                lane_d  = '0;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_comb begin
        vbuf_d      = vbuf_q;
        rsp_valid_d = 1'b0;
        rsp_vec_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_vdata_d = rsp_vdata_q;
        if (s1_valid_q) begin
            if (s1_vec_q) begin
                vbuf_d[s1_lane_q*WORD_W +: WORD_W] = mem_rdata;
                if (s1_last_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_vec_d   = 1'b1;
                    rsp_vdata_d = vbuf_d;
                end
            end else begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            base_q      <= '0;
            burst_we_q  <= 1'b0;
            vwdata_q    <= '0;
            ready_q     <= 1'b1;
            s1_valid_q  <= 1'b0;
            s1_vec_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_lane_q   <= '0;
            vbuf_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_vec_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_vdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            base_q      <= base_d;
            burst_we_q  <= burst_we_d;
            vwdata_q    <= vwdata_d;
            ready_q     <= ready_d;
            s1_valid_q  <= s1_valid_d;
            s1_vec_q    <= s1_vec_d;
            s1_last_q   <= s1_last_d;
            s1_lane_q   <= s1_lane_d;
            vbuf_q      <= vbuf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_vec_q   <= rsp_vec_d;
            rsp_data_q  <= rsp_data_d;
            rsp_vdata_q <= rsp_vdata_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_vec   = rsp_vec_q;
    assign rsp_vdata = rsp_vdata_q;
`else
    logic s1_valid_d, s1_valid_q;
    logic unused_vec_lanes;

    assign unused_vec_lanes = ^req_vwdata[VW-1:WORD_W];

    // Without vector support a vld/vst degenerates to a scalar access on lane 0.
    always_comb begin
        mem_we      = req_valid && req_we;
        mem_waddr   = req_idx;
        mem_raddr   = req_idx;
        mem_wdata   = req_vec ? req_vwdata[WORD_W-1:0] : req_wdata;
        s1_valid_d  = req_valid && !req_we;
        rsp_valid_d = s1_valid_q;
        rsp_data_d  = s1_valid_q ? mem_rdata : rsp_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = 1'b1;
    assign rsp_vec   = 1'b0;
    assign rsp_vdata = '0;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; vector scenarios run only when the
// design is built with DMEM_VEC_EN, the scalar-fallback scenario otherwise.
module tb_dmem_responder;
    import cpu_pkg::*;

    localparam int DEPTH_LOG2 = 10;
    localparam int VLEN       = 4;
    localparam int VW         = WORD_W * VLEN;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef DMEM_VEC_EN
    localparam bit VEC_EN = 1'b1;
`else
    localparam bit VEC_EN = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic        vec;
        logic [15:0] data;
        logic [VW-1:0] vdata;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic          req_vec = 1'b0;
    logic [15:0]   req_addr = '0;
    logic [15:0]   req_wdata = '0;
    logic [VW-1:0] req_vwdata = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_vec;
    logic [15:0]   rsp_data;
    logic [VW-1:0] rsp_vdata;

    int            n_vec = 0;
    int            n_miss = 0;
    int            cyc = 0;
    rsp_t          exp_q[$];
    rsp_t          obs_q[$];
    rsp_t          mon_r;
    logic [15:0]   model_mem [DEPTH];
    logic [15:0]   last_data = '0;
    logic [VW-1:0] last_vdata = '0;

    dmem_responder #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .VLEN      (VLEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_vec   (req_vec),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_vwdata(req_vwdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_vec   (rsp_vec),
        .rsp_data  (rsp_data),
        .rsp_vdata (rsp_vdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
            mon_r.cyc   = cyc;
            mon_r.vec   = rsp_vec;
            mon_r.data  = rsp_data;
            mon_r.vdata = rsp_vdata;
            obs_q.push_back(mon_r);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one request for a single cycle; updates the memory model and
    // pushes the expected response (with held values) for loads.
    task automatic send(input logic we, input logic vec, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [VW-1:0] vwdata);
        rsp_t e;
        int   guard = 0;
        int   a;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL send_ready: req_ready=%b after %0d cycles, want 1", req_ready, guard);
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_vec    = vec;
        req_addr   = addr;
        req_wdata  = wdata;
        req_vwdata = vwdata;
        a = int'(addr) % DEPTH;
        if (we) begin
            if (vec && VEC_EN) begin
                for (int i = 0; i < VLEN; i++)
                    model_mem[(a + i) % DEPTH] = vwdata[i*WORD_W +: WORD_W];
            end else begin
                model_mem[a] = vec ? vwdata[WORD_W-1:0] : wdata;
            end
        end else begin
            e.vec = vec && VEC_EN;
            if (e.vec) begin
                e.cyc = cyc + VLEN + 1;
                for (int i = 0; i < VLEN; i++)
                    last_vdata[i*WORD_W +: WORD_W] = model_mem[(a + i) % DEPTH];
            end else begin
                e.cyc = cyc + 2;
                last_data = model_mem[a];
            end
            e.data  = last_data;
            e.vdata = last_vdata;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_vec   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_vec += 5;
        if (req_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL reset_ready: got %b, want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_rsp_valid: got %b, want 0", rsp_valid); end
        if (rsp_vec !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_rsp_vec: got %b, want 0", rsp_vec); end
        if (rsp_data !== 16'h0) begin n_miss++; $display("[TB] FAIL reset_rsp_data: got %h, want 0", rsp_data); end
        if (rsp_vdata !== '0) begin n_miss++; $display("[TB] FAIL reset_rsp_vdata: got %h, want 0", rsp_vdata); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        rsp_t e, o;
        send(1'b1, 1'b0, 16'd5, 16'h1234, {4{16'hDEAD}});
        send(1'b0, 1'b0, 16'd5, 16'h0, '0);
        send(1'b1, 1'b0, 16'h8009, 16'h5A5A, '0);
        send(1'b0, 1'b0, 16'd9, 16'h0, '0);
        repeat (10) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_miss++;
                $display("[TB] FAIL store_load_rsp: no response, want data=%h at cycle %0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.vec !== e.vec || o.data !== e.data || o.vdata !== e.vdata) begin
                    n_miss++;
                    $display("[TB] FAIL store_load_rsp: got cyc=%0d vec=%b data=%h vdata=%h, want cyc=%0d vec=%b data=%h vdata=%h",
                             o.cyc, o.vec, o.data, o.vdata, e.cyc, e.vec, e.data, e.vdata);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_miss++;
            $display("[TB] FAIL store_load_extra: got %0d unexpected responses, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        rsp_t e, o;
        for (int i = 1; i <= 3; i++)
            send(1'b1, 1'b0, 16'(i), 16'($urandom_range(16'hFFFF)), '0);
        for (int i = 1; i <= 3; i++)
            send(1'b0, 1'b0, 16'(i), 16'h0, '0);
        repeat (10) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_miss++;
                $display("[TB] FAIL b2b_rsp: no response, want data=%h at cycle %0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.vec !== e.vec || o.data !== e.data || o.vdata !== e.vdata) begin
                    n_miss++;
                    $display("[TB] FAIL b2b_rsp: got cyc=%0d vec=%b data=%h vdata=%h, want cyc=%0d vec=%b data=%h vdata=%h",
                             o.cyc, o.vec, o.data, o.vdata, e.cyc, e.vec, e.data, e.vdata);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_miss++;
            $display("[TB] FAIL b2b_extra: got %0d unexpected responses, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

`ifdef DMEM_VEC_EN
    task automatic test_vector_wrap();
        rsp_t e, o;
        for (int k = 0; k < 2; k++) begin
            send(k == 0, 1'b1, 16'h03FE, 16'h0, {16'd4, 16'd3, 16'd2, 16'd1});
            for (int c = 1; c <= VLEN; c++) begin
                @(negedge clk);
                n_vec++;
                if (req_ready !== (c == VLEN)) begin
                    n_miss++;
                    $display("[TB] FAIL vec_ready: op %0d cycle N+%0d got %b, want %b", k, c, req_ready, c == VLEN);
                end
            end
        end
        send(1'b0, 1'b0, 16'h1400, 16'h0, '0);
        send(1'b0, 1'b0, 16'h03FF, 16'h0, '0);
        repeat (10) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_miss++;
                $display("[TB] FAIL vec_rsp: no response, want vdata=%h at cycle %0d", e.vdata, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.vec !== e.vec || o.data !== e.data || o.vdata !== e.vdata) begin
                    n_miss++;
                    $display("[TB] FAIL vec_rsp: got cyc=%0d vec=%b data=%h vdata=%h, want cyc=%0d vec=%b data=%h vdata=%h",
                             o.cyc, o.vec, o.data, o.vdata, e.cyc, e.vec, e.data, e.vdata);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_miss++;
            $display("[TB] FAIL vec_extra: got %0d unexpected responses, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_midburst();
        rsp_t e, o;
        send(1'b0, 1'b1, 16'h0010, 16'h0, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec += 5;
        if (req_ready !== 1'b1) begin n_miss++; $display("[TB] FAIL midburst_ready: got %b, want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL midburst_rsp_valid: got %b, want 0", rsp_valid); end
        if (rsp_vec !== 1'b0) begin n_miss++; $display("[TB] FAIL midburst_rsp_vec: got %b, want 0", rsp_vec); end
        if (rsp_data !== 16'h0) begin n_miss++; $display("[TB] FAIL midburst_rsp_data: got %h, want 0", rsp_data); end
        if (rsp_vdata !== '0) begin n_miss++; $display("[TB] FAIL midburst_rsp_vdata: got %h, want 0", rsp_vdata); end
        void'(exp_q.pop_back());
        last_data  = '0;
        last_vdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 1'b0, 16'd5, 16'h0, '0);
        repeat (10) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_miss++;
                $display("[TB] FAIL midburst_rsp: no response, want data=%h at cycle %0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.vec !== e.vec || o.data !== e.data || o.vdata !== e.vdata) begin
                    n_miss++;
                    $display("[TB] FAIL midburst_rsp: got cyc=%0d vec=%b data=%h vdata=%h, want cyc=%0d vec=%b data=%h vdata=%h",
                             o.cyc, o.vec, o.data, o.vdata, e.cyc, e.vec, e.data, e.vdata);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_miss++;
            $display("[TB] FAIL midburst_extra: got %0d unexpected responses, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask
`else
    task automatic test_vld_scalar();
        rsp_t e, o;
        send(1'b1, 1'b1, 16'd7, 16'h1111, {16'h4444, 16'h3333, 16'h2222, 16'hBEEF});
        send(1'b0, 1'b1, 16'd7, 16'h0, '0);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL novec_ready: got %b, want 1", req_ready);
        end
        repeat (10) @(negedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_miss++;
                $display("[TB] FAIL novec_rsp: no response, want data=%h at cycle %0d", e.data, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.vec !== e.vec || o.data !== e.data || o.vdata !== e.vdata) begin
                    n_miss++;
                    $display("[TB] FAIL novec_rsp: got cyc=%0d vec=%b data=%h vdata=%h, want cyc=%0d vec=%b data=%h vdata=%h",
                             o.cyc, o.vec, o.data, o.vdata, e.cyc, e.vec, e.data, e.vdata);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_miss++;
            $display("[TB] FAIL novec_extra: got %0d unexpected responses, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
`ifdef DMEM_VEC_EN
        test_vector_wrap();
        test_reset_midburst();
`else
        test_vld_scalar();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
